regfile_nrd: RTL and testbench

Parametrised register file that generalises the 32x32 fixed-width read mux to arbitrary WIDTH, DEPTH and read-port count.
- DEPTH registers of WIDTH bits.
- One synchronous write port.
- NUM_RD independent combinational read ports, each built from a parametrised DEPTH:1 by WIDTH mux.
- Optional hardwired zero register.
- Sits in the CPU datapath between decode (addresses) and ALU (operands).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/mux_n_by_w.sv | 22 ++
 rtl/regfile_nrd.sv | 84 ++++++++
 tb/tb_regfile_nrd.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_pkg;

  localparam int WR_COUNT_W = 16;
  localparam int MAX_NUM_RD = 4;
  localparam int MAX_DEPTH  = 256;

  // Smallest r with 2**r >= n; usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_by_w.sv
// N:1 mux of W-bit words from a flattened bus; a select >= N yields zero.
module mux_n_by_w
  import regfile_pkg::*;
#(
  parameter int N   = 32,
  parameter int W   = 32,
  parameter int S_W = clog2(N)
) (
  input  logic [N*W-1:0] in_i,
  input  logic [S_W-1:0] sel_i,
  output logic [W-1:0]   out_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives out_o and no latch is inferred.
    out_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == S_W'(i)) out_o = in_i[i*W +: W];
    end
  end

endmodule

// File: rtl/regfile_nrd.sv
// DEPTH x WIDTH register file, one write port, NUM_RD combinational read ports.
// Optional same-cycle write forwarding: define REGFILE_WRITE_BYPASS_EN.
module regfile_nrd
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [WR_COUNT_W-1:0]   wr_count
);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [WR_COUNT_W-1:0]  wr_count_q, wr_count_d;
  logic                   addr_known, wr_in_range, wr_is_zero, wr_commit;

  // An unknown address must not scatter a write, so it is rejected outright.
  assign addr_known  = !$isunknown(wr_addr);
  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_commit   = wr_en && !reset && addr_known && wr_in_range && !wr_is_zero;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit && (wr_count_q != '1)) wr_count_d = wr_count_q + WR_COUNT_W'(1);
  end

  // NOTE: the array is reset because reads must return 0 after reset; this rules out RAM macros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      if (wr_commit) mem_q[wr_addr] <= wr_data;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  mux_out;
    logic [WIDTH-1:0]  rdata;

    assign raddr = rd_addr[k*ADDR_W +: ADDR_W];

    mux_n_by_w #(
      .N  (DEPTH),
      .W  (WIDTH),
      .S_W(ADDR_W)
    ) u_mux (
      .in_i (mem_flat),
      .sel_i(raddr),
      .out_o(mux_out)
    );

    // Out-of-range reads are zeroed by the mux; forwarding only fires on committed writes.
    always_comb begin
      rdata = mux_out;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_commit && (raddr == wr_addr)) rdata = wr_data;
`endif
      if (((ZERO_REG != 0) && (raddr == '0)) || reset) rdata = '0;
    end

    assign rd_data[k*WIDTH +: WIDTH] = rdata;
  end

endmodule

// File: tb/tb_regfile_nrd.sv
// Self-checking bench for regfile_nrd: default 32x32/2-port instance plus a 20-deep 3-port one.
module tb_regfile_nrd;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [15:0] a_wr_count;
  logic        b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [15:0] b_wr_count;

  always #5 clk = ~clk;

  regfile_nrd u_dut_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_count(a_wr_count)
  );

  regfile_nrd #(.WIDTH(32), .DEPTH(20), .NUM_RD(3), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_count(b_wr_count)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [15:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [15:0] ecnt;
  } exp_t;

  vec_t vecs[63];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int a);
    return (a == 0) ? 32'h0 : 32'h100 + 32'(a);
  endfunction

  function automatic vec_t mk(input bit we, input int wa, input int ra0, input int ra1,
                              input int cnt);
    vec_t v;
    v.we   = we;
    v.wa   = 5'(wa);
    v.wd   = sweep_val(wa);
    v.ra0  = 5'(ra0);
    v.ra1  = 5'(ra1);
    v.e0   = sweep_val(ra0);
    v.e1   = sweep_val(ra1);
    v.ecnt = 16'(cnt);
    return v;
  endfunction

  initial begin
    exp_t        e;
    logic [15:0] exp_cnt;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    // Writes to regs 1..31 checked right after each edge, then a crossed sweep.
    for (int i = 1; i <= 31; i++) vecs[i-1] = mk(1'b1, i, i, i - 1, 1 + i);
    for (int j = 0; j <= 31; j++) vecs[31+j] = mk(1'b0, 0, j, 31 - j, 32);

    reset = 1'b1;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    #3;
    check("reset_rd_a", a_rd_data, 64'h0);
    check("reset_cnt_a", a_wr_count, 16'h0);
    check("reset_cnt_b", b_wr_count, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Write latency on reg 7.
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678; a_rd_addr = {5'd0, 5'd7};
    #1;
    check("lat_before", a_rd_data[31:0], BYP ? 32'h12345678 : 32'h0);
    tick();
    a_wr_en = 1'b0;
    check("lat_after", a_rd_data[31:0], 32'h12345678);
    check("lat_cnt", a_wr_count, 16'd1);

    // Zero register ignores writes and always reads 0.
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF; a_rd_addr = {5'd0, 5'd0};
    #1;
    check("zero_before_p0", a_rd_data[31:0], 32'h0);
    check("zero_before_p1", a_rd_data[63:32], 32'h0);
    tick();
    a_wr_en = 1'b0;
    check("zero_after_p0", a_rd_data[31:0], 32'h0);
    check("zero_after_p1", a_rd_data[63:32], 32'h0);
    check("zero_cnt", a_wr_count, 16'd1);

    for (int v = 0; v < 63; v++) begin
      a_wr_en = vecs[v].we; a_wr_addr = vecs[v].wa; a_wr_data = vecs[v].wd;
      sb.push_back('{e0: vecs[v].e0, e1: vecs[v].e1, ecnt: vecs[v].ecnt});
      tick();
      a_wr_en = 1'b0;
      a_rd_addr = {vecs[v].ra1, vecs[v].ra0};
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_p0", v), a_rd_data[31:0], e.e0);
      check($sformatf("vec%0d_p1", v), a_rd_data[63:32], e.e1);
      check($sformatf("vec%0d_cnt", v), a_wr_count, e.ecnt);
    end

    // Asynchronous reset in mid-cycle.
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd5, 5'd5};
    tick();
    a_wr_en = 1'b0;
    check("rst_pre_p0", a_rd_data[31:0], 32'hDEADBEEF);
    check("rst_pre_cnt", a_wr_count, 16'd33);
    #2 reset = 1'b1;
    #1;
    check("rst_async_p0", a_rd_data[31:0], 32'h0);
    check("rst_async_p1", a_rd_data[63:32], 32'h0);
    check("rst_async_cnt", a_wr_count, 16'h0);

    // A write during reset is lost.
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hAAAA5555; a_rd_addr = {5'd9, 5'd9};
    tick();
    check("rst_wr_cnt", a_wr_count, 16'h0);
    check("rst_wr_rd", a_rd_data[31:0], 32'h0);
    a_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_lost_rd", a_rd_data[31:0], 32'h0);
    check("rst_lost_cnt", a_wr_count, 16'h0);

    // Non-power-of-two depth: out-of-range and last-entry accesses.
    tick();
    b_wr_en = 1'b1; b_wr_addr = 5'd25; b_wr_data = 32'h11111111; b_rd_addr = {5'd25, 5'd25, 5'd19};
    #1;
    check("b_oor_before_p2", b_rd_data[95:64], 32'h0);
    tick();
    check("b_oor_cnt", b_wr_count, 16'h0);
    check("b_oor_p2", b_rd_data[95:64], 32'h0);
    b_wr_addr = 5'd19; b_wr_data = 32'hCAFE0019;
    #1;
    check("b_19_before_p0", b_rd_data[31:0], BYP ? 32'hCAFE0019 : 32'h0);
    tick();
    check("b_19_p0", b_rd_data[31:0], 32'hCAFE0019);
    b_rd_addr = {5'd25, 5'd19, 5'd0};
    b_wr_addr = 5'd0; b_wr_data = 32'hFFFFFFFF;
    #1;
    check("b_19_p1", b_rd_data[63:32], 32'hCAFE0019);
    check("b_25_p2", b_rd_data[95:64], 32'h0);
    check("b_19_cnt", b_wr_count, 16'd1);
    tick();
    b_wr_en = 1'b0;
    check("b_zero_p0", b_rd_data[31:0], 32'h0);
    check("b_zero_cnt", b_wr_count, 16'd1);

    // Saturation of the write counter.
    exp_cnt = 16'h0;
    last_addr = '0;
    last_data = '0;
    for (int n = 1; n <= 65540; n++) begin
      last_addr = 5'(1 + (n % 31));
      last_data = 32'(n);
      a_wr_en = 1'b1; a_wr_addr = last_addr; a_wr_data = last_data;
      tick();
      exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
      if (n == 65534 || n == 65535) check($sformatf("sat_cnt_%0d", n), a_wr_count, exp_cnt);
    end
    a_wr_en = 1'b0;
    a_rd_addr = {5'd0, last_addr};
    #1;
    check("sat_final_cnt", a_wr_count, 16'hFFFF);
    check("sat_last_data", a_rd_data[31:0], 32'h00010004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
